// File: rtl/neuron_mac_seq.sv
// Sequential single-neuron multiply-accumulate controller.
// All arithmetic runs on an external combinational ALU. The optional ReLU clamps the final sum.
module neuron_mac_seq #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_inputs,
    input  logic [15:0]      bias,
    input  logic             relu_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      x_in,
    input  logic [15:0]      w_in,
    output logic [15:0]      alu_op1,
    output logic [15:0]      alu_op2,
    output logic             alu_en,
    output logic [1:0]       alu_op_sel,
    input  logic [15:0]      alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             busy
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WAIT_IN = 3'd1;
    localparam logic [2:0] MUL     = 3'd2;
    localparam logic [2:0] ADD     = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b10;

    logic [2:0]       state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic [15:0]      prod_q, prod_d;
    logic [15:0]      x_reg_q, x_reg_d;
    logic [15:0]      w_reg_q, w_reg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] tgt_q, tgt_d;
    logic             relu_en_q, relu_en_d;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        prod_d    = prod_q;
        x_reg_d   = x_reg_q;
        w_reg_d   = w_reg_q;
        cnt_d     = cnt_q;
        tgt_d     = tgt_q;
        relu_en_d = relu_en_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d     = bias;
                    relu_en_d = relu_en;
                    if (num_inputs != '0) begin
                        cnt_d   = '0;
                        tgt_d   = num_inputs;
                        state_d = WAIT_IN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WAIT_IN: begin
                if (in_valid) begin
                    x_reg_d = x_in;
                    w_reg_d = w_in;
                    state_d = MUL;
                end
            end
            MUL: begin
                prod_d  = alu_result;
                state_d = ADD;
            end
            ADD: begin
                acc_d   = alu_result;
                cnt_d   = cnt_inc;
                state_d = (cnt_inc == tgt_q) ? DONE : WAIT_IN;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            prod_q    <= '0;
            x_reg_q   <= '0;
            w_reg_q   <= '0;
            cnt_q     <= '0;
            tgt_q     <= '0;
            relu_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            prod_q    <= prod_d;
            x_reg_q   <= x_reg_d;
            w_reg_q   <= w_reg_d;
            cnt_q     <= cnt_d;
            tgt_q     <= tgt_d;
            relu_en_q <= relu_en_d;
        end
    end

    // Outputs decode from the registered state only, so reset zeroes them immediately.
    always_comb begin
        in_ready   = 1'b0;
        alu_en     = 1'b0;
        alu_op_sel = 2'b00;
        alu_op1    = '0;
        alu_op2    = '0;
        out_valid  = 1'b0;
        out_data   = '0;
        case (state_q)
            WAIT_IN: in_ready = 1'b1;
            MUL: begin
                alu_en     = 1'b1;
                alu_op_sel = OP_MUL;
                alu_op1    = x_reg_q;
                alu_op2    = w_reg_q;
            end
            ADD: begin
                alu_en     = 1'b1;
                alu_op_sel = OP_ADD;
                alu_op1    = acc_q;
                alu_op2    = prod_q;
            end
            DONE: begin
                out_valid = 1'b1;
                out_data  = (relu_en_q && acc_q[15]) ? 16'h0000 : acc_q;
            end
            default: ;
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule

// File: doc/neuron_mac_seq.md
NEURON_MAC_SEQ -- requirements
Module: neuron_mac_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 4, meaning width of the element counter (max 2^CNT_W-1 inputs per neuron).
REQ-002 SHALL have port clk, input, 1, the single clock; every register updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, one-cycle request to begin a neuron; sampled only in IDLE.
REQ-005 SHALL have port num_inputs, input, CNT_W, number of x/w pairs; sampled with start.
REQ-006 SHALL have port bias, input, 16, initial accumulator value; sampled with start.
REQ-007 SHALL have port relu_en, input, 1, when 1, a negative final sum is clamped to 0; sampled with start.
REQ-008 SHALL have ports in_valid (input, 1), in_ready (output, 1), x_in (input, 16), w_in (input, 16), the element handshake.
REQ-009 SHALL have ports alu_op1 (output, 16), alu_op2 (output, 16), alu_en (output, 1), alu_op_sel (output, 2), driving the combinational ALU.
REQ-010 SHALL have port alu_result, input, 16, the ALU output, sampled the same cycle it is driven.
REQ-011 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, 16), the result handshake.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT_IN, MUL, ADD, DONE.
REQ-014 IDLE: on start with num_inputs!=0, load acc<=bias, cnt<=0, tgt<=num_inputs, and go to WAIT_IN; on start with num_inputs==0, load acc<=bias and go to DONE.
REQ-015 In WAIT_IN, in_ready SHALL be 1; on in_valid&&in_ready, capture x_in/w_in and go to MUL; otherwise remain.
REQ-016 in_ready SHALL be 0 in every state other than WAIT_IN.
REQ-017 MUL: alu_en=1, alu_op_sel=2'b10, alu_op1=x_reg, alu_op2=w_reg; prod<=alu_result; go to ADD.
REQ-018 ADD: alu_en=1, alu_op_sel=2'b00, alu_op1=acc, alu_op2=prod; acc<=alu_result; cnt<=cnt+1; if cnt+1==tgt go to DONE, else go to WAIT_IN.
REQ-019 In IDLE, WAIT_IN and DONE, alu_en SHALL be 0 and alu_op1, alu_op2 and alu_op_sel SHALL be 0.
REQ-020 Arithmetic SHALL be entirely delegated to the ALU; the block SHALL add no widening, saturation or rounding, and acc wraps exactly as alu_result does.
REQ-021 DONE: out_valid=1 and out_data=(relu_en_reg && acc[15]) ? 16'h0000 : acc, both held stable until out_ready=1.
REQ-022 On out_valid&&out_ready, the block SHALL return to IDLE; out_valid SHALL be 0 in the next cycle.
REQ-023 Per-element latency SHALL be exactly 3 cycles (WAIT_IN accept, MUL, ADD) when in_valid is held high; an N-element neuron reaches DONE 3N+1 cycles after start.
REQ-024 A start asserted while busy=1 SHALL be ignored, and num_inputs/bias/relu_en changes SHALL have no effect after capture.
REQ-025 out_valid SHALL be 0 in every state other than DONE, and out_data SHALL be 0 when out_valid=0.

Reset
REQ-026 rst=1 SHALL immediately force state=IDLE, acc=0, prod=0, x_reg=0, w_reg=0, cnt=0, tgt=0, relu_en_reg=0, independent of clk.
REQ-027 During and after reset, all outputs SHALL be 0: in_ready, out_valid, out_data, busy, alu_en, alu_op1, alu_op2, alu_op_sel.
REQ-028 Reset mid-neuron SHALL discard the partial sum; the next start SHALL begin a fresh neuron.

Verification
REQ-029 Bench SHALL pair the block with an ALU model (op 00: a+b mod 2^16; op 10: low 16 bits of a*b).
REQ-030 Case: start, num_inputs=3, bias=5, pairs (2,3),(4,1),(1,1), in_valid held 1 -> out_valid at cycle 10 after start, out_data=16.
REQ-031 Case: start, num_inputs=0, bias=16'h0007 -> DONE the next cycle with out_data=7 and no alu_en pulse.
REQ-032 Case: relu_en=1, num_inputs=1, bias=0, pair (16'hFFFF,2) -> out_data=0; repeat with relu_en=0 -> out_data=16'hFFFE.
REQ-033 Case: in_valid gapped 2 cycles between elements and out_ready held 0 for 4 cycles -> result is unchanged, out_data is stable while waiting, and in_ready=0 outside WAIT_IN.
REQ-034 Case: rst pulsed during ADD of element 2 -> all outputs are 0 at once, a second start during the earlier run was ignored, and a new run yields its correct sum.
